// File: rtl/cdec8_seq_pkg.sv
// Shared encodings for the CDEC8 control sequencer: transfer codes, opcodes,
// state codes, ALU operations and the idle control word.
package cdec8_seq_pkg;

   localparam logic [2:0] XS_PC = 3'b000, XS_A = 3'b001, XS_B = 3'b010, XS_C = 3'b011,
                          XS_R  = 3'b100, XS_RDR = 3'b101, XS_NONE = 3'b111;

   localparam logic [2:0] XD_PC  = 3'b000, XD_A = 3'b001, XD_B = 3'b010, XD_C = 3'b011,
                          XD_MAR = 3'b100, XD_WDR = 3'b101, XD_T = 3'b110, XD_I = 3'b111;

   localparam logic [3:0] OP_NOP = 4'h0, OP_HLT = 4'h1, OP_MOV = 4'h2, OP_LDI = 4'h3,
                          OP_LD  = 4'h4, OP_ST  = 4'h5, OP_JMP = 4'h6, OP_JCC = 4'h7,
                          OP_ADD = 4'h8, OP_SUB = 4'h9, OP_AND = 4'hA, OP_OR  = 4'hB,
                          OP_XOR = 4'hC, OP_CMP = 4'hD;

   localparam logic [4:0] ALU_PASS = 5'd0, ALU_INC = 5'd1, ALU_ADD = 5'd2, ALU_SUB = 5'd3,
                          ALU_AND  = 5'd4, ALU_OR  = 5'd5, ALU_XOR = 5'd6, ALU_CMP = 5'd7;

   localparam logic [1:0] MM_IDLE = 2'b00, MM_RD = 2'b10, MM_WR = 2'b01;

   typedef enum logic [7:0] {
      ST_F0   = 8'h00, ST_F1 = 8'h01, ST_F2 = 8'h02, ST_F3 = 8'h03, ST_WAIT = 8'h04,
      ST_E0   = 8'h10, ST_E1 = 8'h11, ST_E2 = 8'h12, ST_E3 = 8'h13, ST_E4 = 8'h14,
      ST_E5   = 8'h15, ST_HALT = 8'hFF
   } state_t;

   typedef struct packed {
      logic [1:0] mmrw;
      logic       fwr;
      logic       rwr;
      logic [2:0] xdst;
      logic [4:0] aluop;
      logic [2:0] xsrc;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '{mmrw: MM_IDLE, fwr: 1'b0, rwr: 1'b0, xdst: XD_T,
                                   aluop: ALU_PASS, xsrc: XS_NONE};
   localparam ctrl_t CTRL_RDINC = '{mmrw: MM_RD, fwr: 1'b0, rwr: 1'b1, xdst: XD_T,
                                    aluop: ALU_INC, xsrc: XS_PC};
   localparam logic [14:0] IDLE_WORD = CTRL_IDLE;

   // Register field 11 aliases A.
   function automatic logic [2:0] reg_code(input logic [1:0] f);
      return (f == 2'b11) ? 3'b001 : ({1'b0, f} + 3'd1);
   endfunction

   function automatic ctrl_t xfer(input logic [2:0] s, input logic [2:0] d);
      ctrl_t c;
      c      = CTRL_IDLE;
      c.xsrc = s;
      c.xdst = d;
      return c;
   endfunction

   function automatic logic [4:0] alu_code(input logic [3:0] op);
      case (op)
         OP_ADD:  return ALU_ADD;
         OP_SUB:  return ALU_SUB;
         OP_AND:  return ALU_AND;
         OP_OR:   return ALU_OR;
         OP_XOR:  return ALU_XOR;
         OP_CMP:  return ALU_CMP;
         default: return ALU_PASS;
      endcase
   endfunction

endpackage

// File: rtl/cdec8_seq_dec.sv
// Combinational decode of {state, I, SZCy} into the control word and the
// last-step flag that returns the sequencer to instruction fetch.
module cdec8_seq_dec
   import cdec8_seq_pkg::*;
(
   input  logic [7:0]  state,
   input  logic [7:0]  I,
   input  logic [2:0]  SZCy,
   output logic [14:0] ctrl,
   output logic        last_step
);

   ctrl_t      c;
   logic [3:0] op;
   logic [2:0] dst;
   logic [2:0] src;
   logic       opf;
   logic       alu;
   logic       taken;

   assign op   = I[7:4];
   assign dst  = reg_code(I[3:2]);
   assign src  = reg_code(I[1:0]);
   assign opf  = (op >= OP_LDI) && (op <= OP_JCC);
   assign alu  = (op >= OP_ADD) && (op <= OP_CMP);
   assign ctrl = c;

   always_comb begin
      taken = 1'b1;
      case (I[1:0])
         2'b00:   taken = SZCy[1];
         2'b01:   taken = SZCy[0];
         2'b10:   taken = SZCy[2];
         default: taken = 1'b1;
      endcase
   end

   always_comb begin
      c         = CTRL_IDLE;
      last_step = 1'b0;
      case (state)
         ST_F0: c = xfer(XS_PC, XD_MAR);
         ST_F1: c = CTRL_RDINC;
         ST_F2: c = xfer(XS_R, XD_PC);
         ST_F3: c = xfer(XS_RDR, XD_I);
         ST_E0: begin
            if (opf)                c = xfer(XS_PC, XD_MAR);
            else if (alu)           c = xfer(src, XD_T);
            else if (op == OP_MOV) begin
               c         = xfer(src, dst);
               last_step = 1'b1;
            end
            else                    last_step = (op != OP_HLT);
         end
         ST_E1: begin
            if (opf)      c = CTRL_RDINC;
            else if (alu) begin
               c.xsrc    = dst;
               c.aluop   = alu_code(op);
               c.rwr     = 1'b1;
               c.fwr     = 1'b1;
               last_step = (op == OP_CMP);
            end
            else          last_step = 1'b1;
         end
         ST_E2: begin
            if (opf)      c = xfer(XS_R, XD_PC);
            else begin
               if (alu) c = xfer(XS_R, dst);
               last_step = 1'b1;
            end
         end
         ST_E3: begin
            last_step = 1'b1;
            case (op)
               OP_LDI:       c = xfer(XS_RDR, dst);
               OP_LD, OP_ST: begin
                  c         = xfer(XS_RDR, XD_MAR);
                  last_step = 1'b0;
               end
               OP_JMP:       c = xfer(XS_RDR, XD_PC);
               OP_JCC:       if (taken) c = xfer(XS_RDR, XD_PC);
               default:      ;
            endcase
         end
         ST_E4: begin
            if (op == OP_LD)      c.mmrw = MM_RD;
            else if (op == OP_ST) c = xfer(src, XD_WDR);
            else                  last_step = 1'b1;
         end
         ST_E5: begin
            last_step = 1'b1;
            if (op == OP_LD)      c = xfer(XS_RDR, dst);
            else if (op == OP_ST) c.mmrw = MM_WR;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/cdec8_seq.sv
// CDEC8 fetch/execute sequencer: state register, decode and optional single-step
// gate (CDEC8_STEP_EN adds the step port and the WAIT state before every fetch).
module cdec8_seq
   import cdec8_seq_pkg::*;
(
   input  logic        clock,
   input  logic        reset_N,
`ifdef CDEC8_STEP_EN
   input  logic        step,
`endif
   input  logic [7:0]  I,
   input  logic [2:0]  SZCy,
   output logic [14:0] ctrl,
   output logic [7:0]  state,
   output logic        halted
);

`ifdef CDEC8_STEP_EN
   // Reset counts as entering F0, so stepping mode starts parked in WAIT.
   localparam state_t ST_ENTRY = ST_WAIT;
   logic [2:0] step_q;
   logic       step_rise;

   always_ff @(posedge clock or negedge reset_N) begin
      if (!reset_N) step_q <= 3'b000;
      else          step_q <= {step_q[1:0], step};
   end
   assign step_rise = step_q[1] & ~step_q[2];
`else
   localparam state_t ST_ENTRY = ST_F0;
`endif

   state_t      cur;
   state_t      nxt;
   logic [14:0] dec_ctrl;
   logic        last_step;

   cdec8_seq_dec u_dec (
      .state     (cur),
      .I         (I),
      .SZCy      (SZCy),
      .ctrl      (dec_ctrl),
      .last_step (last_step)
   );

   always_ff @(posedge clock or negedge reset_N) begin
      if (!reset_N) cur <= ST_ENTRY;
      else          cur <= nxt;
   end

   always_comb begin
      nxt = cur;
      case (cur)
         ST_F0:   nxt = ST_F1;
         ST_F1:   nxt = ST_F2;
         ST_F2:   nxt = ST_F3;
         ST_F3:   nxt = ST_E0;
         ST_E0:   nxt = (I[7:4] == OP_HLT) ? ST_HALT : (last_step ? ST_ENTRY : ST_E1);
         ST_E1:   nxt = last_step ? ST_ENTRY : ST_E2;
         ST_E2:   nxt = last_step ? ST_ENTRY : ST_E3;
         ST_E3:   nxt = last_step ? ST_ENTRY : ST_E4;
         ST_E4:   nxt = last_step ? ST_ENTRY : ST_E5;
         ST_E5:   nxt = ST_ENTRY;
         ST_HALT: nxt = ST_HALT;
`ifdef CDEC8_STEP_EN
         ST_WAIT: nxt = step_rise ? ST_F0 : ST_WAIT;
`else
         ST_WAIT: nxt = ST_F0;
`endif
         default: nxt = ST_ENTRY;
      endcase
   end

   // Held idle while reset is low so an in-flight write strobe dies immediately.
   assign ctrl   = reset_N ? dec_ctrl : IDLE_WORD;
   assign state  = cur;
   assign halted = (cur == ST_HALT);

endmodule

// File: tb/tb_cdec8_seq.sv
// Scoreboard bench for cdec8_seq: per-instruction expected cycle streams are queued
// by the stimulus and compared every cycle by an independent monitor.
module tb_cdec8_seq;

   localparam logic [2:0] XPC = 3'd0, XA = 3'd1, XR = 3'd4, XRDR = 3'd5, XNONE = 3'd7;
   localparam logic [2:0] DPC = 3'd0, DMAR = 3'd4, DWDR = 3'd5, DT = 3'd6, DI = 3'd7;
   localparam logic [4:0] PASS = 5'd0, INC = 5'd1;

   typedef struct {
      logic [7:0]  st;
      logic [14:0] c;
      logic        h;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset_N = 1'b0;
   logic [7:0]  I = 8'h00;
   logic [2:0]  SZCy = 3'b000;
   logic [14:0] ctrl;
   logic [7:0]  state;
   logic        halted;
`ifdef CDEC8_STEP_EN
   logic        step = 1'b0;
`endif

   exp_t exp_q[$];
   bit   mon_en = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clock = ~clock;

   cdec8_seq dut (
      .clock   (clock),
      .reset_N (reset_N),
`ifdef CDEC8_STEP_EN
      .step    (step),
`endif
      .I       (I),
      .SZCy    (SZCy),
      .ctrl    (ctrl),
      .state   (state),
      .halted  (halted)
   );

   function automatic logic [14:0] w(input logic [1:0] mm, input logic f, input logic r,
                                     input logic [2:0] xd, input logic [4:0] al,
                                     input logic [2:0] xs);
      return {mm, f, r, xd, al, xs};
   endfunction

   function automatic logic [2:0] regc(input logic [1:0] f);
      return (f == 2'd3) ? 3'd1 : (3'(f) + 3'd1);
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
      end
   endtask

   // Reference: expected cycle list of one instruction, straight from the opcode table.
   task automatic gen(input logic [7:0] ins, input logic [2:0] fl, output int n);
      logic [14:0] idle;
      logic [14:0] ex[$];
      logic [3:0]  op;
      logic [2:0]  d, s;
      logic        taken;
      exp_t        e;
      idle  = w(2'b00, 0, 0, DT, PASS, XNONE);
      op    = ins[7:4];
      d     = regc(ins[3:2]);
      s     = regc(ins[1:0]);
      taken = (ins[1:0] == 2'd0) ? fl[1] : (ins[1:0] == 2'd1) ? fl[0] :
              (ins[1:0] == 2'd2) ? fl[2] : 1'b1;
      if (op >= 4'd3 && op <= 4'd7)
         ex = '{w(0, 0, 0, DMAR, PASS, XPC), w(2'b10, 0, 1, DT, INC, XPC), w(0, 0, 0, DPC, PASS, XR)};
      case (op)
         4'd2: ex.push_back(w(0, 0, 0, d, PASS, s));
         4'd3: ex.push_back(w(0, 0, 0, d, PASS, XRDR));
         4'd4: begin
            ex.push_back(w(0, 0, 0, DMAR, PASS, XRDR));
            ex.push_back(w(2'b10, 0, 0, DT, PASS, XNONE));
            ex.push_back(w(0, 0, 0, d, PASS, XRDR));
         end
         4'd5: begin
            ex.push_back(w(0, 0, 0, DMAR, PASS, XRDR));
            ex.push_back(w(0, 0, 0, DWDR, PASS, s));
            ex.push_back(w(2'b01, 0, 0, DT, PASS, XNONE));
         end
         4'd6: ex.push_back(w(0, 0, 0, DPC, PASS, XRDR));
         4'd7: ex.push_back(taken ? w(0, 0, 0, DPC, PASS, XRDR) : idle);
         4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13: begin
            ex.push_back(w(0, 0, 0, DT, PASS, s));
            ex.push_back(w(0, 1, 1, DT, 5'(op) - 5'd6, d));
            if (op != 4'd13) ex.push_back(w(0, 0, 0, d, PASS, XR));
         end
         default: ex.push_back(idle);
      endcase
      e.h = 1'b0;
      e.st = 8'h00; e.c = w(0, 0, 0, DMAR, PASS, XPC);        exp_q.push_back(e);
      e.st = 8'h01; e.c = w(2'b10, 0, 1, DT, INC, XPC);       exp_q.push_back(e);
      e.st = 8'h02; e.c = w(0, 0, 0, DPC, PASS, XR);          exp_q.push_back(e);
      e.st = 8'h03; e.c = w(0, 0, 0, DI, PASS, XRDR);         exp_q.push_back(e);
      foreach (ex[k]) begin
         e.st = 8'h10 + 8'(k);
         e.c  = ex[k];
         exp_q.push_back(e);
      end
      n = 4 + ex.size();
      if (op == 4'd1) begin
         for (int k = 0; k < 20; k++) begin
            e.st = 8'hFF; e.c = idle; e.h = 1'b1;
            exp_q.push_back(e);
         end
         n += 20;
      end
   endtask

   // Called at the negedge of an F0 cycle; returns at the next instruction's F0 negedge.
   task automatic run(input logic [7:0] ins, input logic [2:0] fl);
      int n;
      gen(ins, fl, n);
      repeat (3) @(negedge clock);
      I    = ins;
      SZCy = fl;
      repeat (n - 3) @(negedge clock);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         #1;
         if (mon_en) begin
            if (exp_q.size() == 0) begin
               check("queue_underflow", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check($sformatf("state@%0t", $time), state, e.st);
               check($sformatf("ctrl@%0t st=%0h", $time, e.st), ctrl, e.c);
               check($sformatf("halted@%0t", $time), halted, e.h);
            end
         end
      end
   end

   initial begin
      logic [7:0] d_ins [13] = '{8'h31, 8'h35, 8'h81, 8'h90, 8'h70, 8'h70, 8'h50,
                                 8'h44, 8'h29, 8'hD6, 8'h73, 8'h00, 8'hE0};
      logic [2:0] d_fl  [13] = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b010, 3'b101, 3'b000,
                                 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
      logic [7:0] ins;

      repeat (2) @(negedge clock);
      check("reset_state", state, 8'h00);
      check("reset_ctrl", ctrl, w(0, 0, 0, DT, PASS, XNONE));
      check("reset_halted", halted, 1'b0);

      reset_N = 1'b1;
      mon_en  = 1'b1;
      foreach (d_ins[k]) run(d_ins[k], d_fl[k]);

      // ST aborted by reset in E4: idle word at once, no write strobe afterwards.
      mon_en = 1'b0;
      repeat (3) @(negedge clock);
      I = 8'h50;
      repeat (5) @(negedge clock);
      #1;
      check("abort_e4_state", state, 8'h14);
      check("abort_e4_ctrl", ctrl, w(0, 0, 0, DWDR, PASS, XA));
      reset_N = 1'b0;
      #1;
      check("abort_async_ctrl", ctrl, w(0, 0, 0, DT, PASS, XNONE));
      check("abort_async_state", state, 8'h00);
      @(posedge clock);
      #1;
      check("abort_no_write", ctrl, w(0, 0, 0, DT, PASS, XNONE));
      @(negedge clock);
      reset_N = 1'b1;
      mon_en  = 1'b1;

      for (int k = 0; k < 150; k++) begin
         ins = 8'($urandom);
         if (ins[7:4] == 4'h1) ins[4] = 1'b0;
         run(ins, 3'($urandom_range(0, 7)));
      end

      run(8'h10, 3'b000);
      mon_en = 1'b0;
      check("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach its end, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
